avalon_counter_pio: RTL

AVALON_COUNTER_PIO -- requirements
Module: avalon_counter_pio

---
 rtl/counter_pkg.sv | 31 +++
 rtl/counter_channel.sv | 105 ++++++++++
 rtl/avalon_counter_pio.sv | 118 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Register map, CTRL/STATUS bit positions and CTRL layout shared
//             by the Avalon counter PIO and its channels.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

   localparam logic [1:0] c_reg_ctrl    = 2'd0;
   localparam logic [1:0] c_reg_value   = 2'd1;
   localparam logic [1:0] c_reg_compare = 2'd2;
   localparam logic [1:0] c_reg_status  = 2'd3;

   localparam int c_ctrl_en   = 0;
   localparam int c_ctrl_down = 1;
   localparam int c_ctrl_sat  = 2;

   localparam int c_status_match    = 0;
   localparam int c_status_irq_mask = 1;

   typedef struct packed {
      logic sat;
      logic down;
      logic en;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/counter_channel.sv
// ============================================================================
//  Module   : counter_channel
//  Purpose  : One up/down counter with wrap/saturate, COMPARE and sticky MATCH.
//             IRQ_MASK exists only when AVALON_COUNTER_IRQ_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_channel
   import counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             ctrl_we,
   input  logic             value_we,
   input  logic             compare_we,
   input  logic             status_we,
   input  logic [31:0]      wdata,
   output logic [2:0]       ctrl,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] compare,
   output logic             match
`ifdef AVALON_COUNTER_IRQ_EN
   ,
   output logic             irq_mask
`endif
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   ctrl_t            r_ctrl;
   logic [WIDTH-1:0] r_value;
   logic [WIDTH-1:0] r_compare;
   logic             r_match;
   logic [WIDTH-1:0] w_value_next;
   logic             w_step;
   logic             w_match_set;
   logic             w_unused_wdata;

   assign w_step = tick & r_ctrl.en;

   // A load beats a step; a saturating step at the rail leaves the value alone.
   always_comb begin
      w_value_next = r_value;
      if (value_we) begin
         w_value_next = wdata[WIDTH-1:0];
      end else if (w_step) begin
         if (r_ctrl.down) begin
            if (!(r_ctrl.sat && (r_value == '0))) w_value_next = r_value - c_one;
         end else begin
            if (!(r_ctrl.sat && (r_value == '1))) w_value_next = r_value + c_one;
         end
      end
   end

   assign w_match_set    = (value_we | w_step) && (w_value_next == r_compare);
   assign w_unused_wdata = ^wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl    <= '0;
         r_value   <= '0;
         r_compare <= '0;
         r_match   <= 1'b0;
      end else begin
         r_value <= w_value_next;
         if (ctrl_we) begin
            r_ctrl <= '{sat:  wdata[c_ctrl_sat],
                        down: wdata[c_ctrl_down],
                        en:   wdata[c_ctrl_en]};
         end
         if (compare_we) r_compare <= wdata[WIDTH-1:0];
         if (w_match_set) begin
            r_match <= 1'b1;
         end else if (status_we && wdata[c_status_match]) begin
            r_match <= 1'b0;
         end
      end
   end

`ifdef AVALON_COUNTER_IRQ_EN
   logic r_irq_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_mask <= 1'b0;
      end else if (status_we) begin
         r_irq_mask <= wdata[c_status_irq_mask];
      end
   end

   assign irq_mask = r_irq_mask;
`endif

   assign ctrl    = {r_ctrl.sat, r_ctrl.down, r_ctrl.en};
   assign value   = r_value;
   assign compare = r_compare;
   assign match   = r_match;

endmodule

`default_nettype wire

// File: rtl/avalon_counter_pio.sv
// ============================================================================
//  Module   : avalon_counter_pio
//  Purpose  : Avalon-MM slave with N_CH tick-driven counters; channel 0 drives
//             export_value. Define AVALON_COUNTER_IRQ_EN for IRQ_MASK and irq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_counter_pio
   import counter_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int WIDTH = 8,
   localparam int CH_AW = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CH_AW+1:0]   address,
   input  logic               write,
   input  logic [31:0]        writedata,
   input  logic               read,
   output logic [31:0]        readdata,
   input  logic               tick,
   output logic [WIDTH-1:0]   export_value
`ifdef AVALON_COUNTER_IRQ_EN
   ,
   output logic               irq
`endif
);

   logic [CH_AW-1:0] w_ch;
   logic [1:0]       w_reg;
   logic [2:0]       w_ctrl    [N_CH];
   logic [WIDTH-1:0] w_value   [N_CH];
   logic [WIDTH-1:0] w_compare [N_CH];
   logic [N_CH-1:0]  w_match;
   logic [N_CH-1:0]  w_irq_mask;
   logic [31:0]      w_rdata;
   logic [31:0]      r_readdata;

   assign w_ch  = address[CH_AW+1:2];
   assign w_reg = address[1:0];

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic w_sel;
         assign w_sel = write && (w_ch == CH_AW'(i));

         counter_channel #(
            .WIDTH (WIDTH)
         ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .ctrl_we    (w_sel && (w_reg == c_reg_ctrl)),
            .value_we   (w_sel && (w_reg == c_reg_value)),
            .compare_we (w_sel && (w_reg == c_reg_compare)),
            .status_we  (w_sel && (w_reg == c_reg_status)),
            .wdata      (writedata),
            .ctrl       (w_ctrl[i]),
            .value      (w_value[i]),
            .compare    (w_compare[i]),
            .match      (w_match[i])
`ifdef AVALON_COUNTER_IRQ_EN
            ,
            .irq_mask   (w_irq_mask[i])
`endif
         );
      end
   endgenerate

`ifndef AVALON_COUNTER_IRQ_EN
   assign w_irq_mask = '0;
`endif

   // Channel indices with no instance fall through to the zero default.
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_ch == CH_AW'(i)) begin
            case (w_reg)
               c_reg_ctrl:    w_rdata = {29'd0, w_ctrl[i]};
               c_reg_value:   w_rdata = 32'(w_value[i]);
               c_reg_compare: w_rdata = 32'(w_compare[i]);
               default:       w_rdata = {30'd0, w_irq_mask[i], w_match[i]};
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else if (read) begin
         r_readdata <= w_rdata;
      end
   end

   assign readdata     = r_readdata;
   assign export_value = w_value[0];

`ifdef AVALON_COUNTER_IRQ_EN
   logic r_irq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(w_match & w_irq_mask);
      end
   end

   assign irq = r_irq;
`endif

endmodule

`default_nettype wire
